// File: rtl/alu32_result_stage_pkg.sv
// Shared definitions for the alu32 result stage: occupancy states, opcode
// encodings and flag bit positions.
package alu32_result_stage_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } occ_state_e;

   localparam logic [2:0] OP_NOTA = 3'b000;
   localparam logic [2:0] OP_NOTB = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;
   localparam logic [2:0] OP_ADD  = 3'b110;
   localparam logic [2:0] OP_SUB  = 3'b111;

   localparam int FLG_C = 3;
   localparam int FLG_N = 2;
   localparam int FLG_Z = 1;
   localparam int FLG_V = 0;

   // Only the adder path produces meaningful carry/overflow.
   function automatic logic op_is_arith(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu32_result_stage_if.sv
// Input and output valid/ready streams of the alu32 result stage.
// master = producer/consumer side (mux and register file), slave = the stage.
interface alu32_result_stage_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_result;
   logic [2:0]       in_op;
   logic             in_co;
   logic             in_c_msb;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic [2:0]       out_op;
   logic [3:0]       out_flags;

   modport master (
      output in_valid, in_result, in_op, in_co, in_c_msb, out_ready,
      input  in_ready, out_valid, out_result, out_op, out_flags
   );

   modport slave (
      input  in_valid, in_result, in_op, in_co, in_c_msb, out_ready,
      output in_ready, out_valid, out_result, out_op, out_flags
   );
endinterface

// File: rtl/alu32_result_stage_flag_gen.sv
// Combinational {C,N,Z,V} flag derivation for one result from the result mux.
module alu32_flag_gen
   import alu32_result_stage_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] result,
   input  logic [2:0]       op,
   input  logic             co,
   input  logic             c_msb,
   output logic [3:0]       flags
);

   // N/Z from the result itself; C/V only for add/sub, masked otherwise.
   always_comb begin
      flags        = 4'b0000;
      flags[FLG_N] = result[WIDTH-1];
      flags[FLG_Z] = (result == '0);
      if (op_is_arith(op)) begin
         flags[FLG_C] = co;
         flags[FLG_V] = co ^ c_msb;
      end
   end

endmodule

// File: rtl/alu32_result_stage.sv
// Output stage behind the alu32 result mux: flags, 2-entry FIFO with
// valid/ready handshake on both sides, and a retired-result counter.
//
//  state    | meaning
//  ---------+---------------------------------------------
//  ST_EMPTY | no buffered result, out_valid low
//  ST_ONE   | one result at the head
//  ST_FULL  | two results, input stalled (in_ready low)
module alu32_result_stage
   import alu32_result_stage_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   alu32_result_stage_if.slave  bus,
   output logic [CNT_W-1:0]     retire_cnt
);

   occ_state_e       state, state_nxt;
   logic [WIDTH-1:0] mem_result [2];
   logic [2:0]       mem_op     [2];
   logic [3:0]       mem_flags  [2];
   logic             head;
   logic             tail;
   logic             in_ready_q;
   logic             push;
   logic             pop;
   logic [3:0]       in_flags;

   alu32_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
      .result (bus.in_result),
      .op     (bus.in_op),
      .co     (bus.in_co),
      .c_msb  (bus.in_c_msb),
      .flags  (in_flags)
   );

   assign push = bus.in_valid & in_ready_q;
   assign pop  = (state != ST_EMPTY) & bus.out_ready;
   // In EMPTY the head slot is reused so the last popped value stays visible.
   assign tail = (state == ST_EMPTY) ? head : ~head;

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = (state != ST_EMPTY);
   assign bus.out_result = mem_result[head];
   assign bus.out_op     = mem_op[head];
   assign bus.out_flags  = mem_flags[head];

   // Occupancy state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_EMPTY;
      else          state <= state_nxt;
   end

   // Occupancy next-state from push/pop.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY: if (push) state_nxt = ST_ONE;
         ST_ONE: begin
            if (push && !pop)      state_nxt = ST_FULL;
            else if (!push && pop) state_nxt = ST_EMPTY;
         end
         ST_FULL:  if (pop) state_nxt = ST_ONE;
         default:  state_nxt = ST_EMPTY;
      endcase
   end

   // Storage, head pointer, registered in_ready and retire counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            mem_result[i] <= '0;
            mem_op[i]     <= '0;
            mem_flags[i]  <= '0;
         end
         head       <= 1'b0;
         in_ready_q <= 1'b0;
         retire_cnt <= '0;
      end else begin
         if (push) begin
            mem_result[tail] <= bus.in_result;
            mem_op[tail]     <= bus.in_op;
            mem_flags[tail]  <= in_flags;
         end
         // Advance only when another entry will sit behind the popped one.
         if (pop && ((state == ST_FULL) || push)) head <= ~head;
         in_ready_q <= (state_nxt != ST_FULL);
         if (pop) retire_cnt <= retire_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_alu32_result_stage.sv
// Directed bench for alu32_result_stage: flags per opcode, FIFO stall and
// ordering, counter wrap (4-bit counter) and asynchronous reset.
module tb_alu32_result_stage;

   localparam int CNT_W = 4;

   logic             clk;
   logic             reset_n;
   logic [CNT_W-1:0] retire_cnt;
   int               n_vec;
   int               n_miss;
   int               exp_cnt;

   alu32_result_stage_if #(.WIDTH(32)) bus ();

   alu32_result_stage #(.WIDTH(32), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .retire_cnt (retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running, need finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One result through an empty queue with out_ready=1: visible after the
   // push edge, retired on the following edge.
   task automatic send(input string tag, input logic [31:0] r, input logic [2:0] op,
                       input logic co, input logic cm, input logic [3:0] ef);
      check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid  = 1'b1;
      bus.in_result = r;
      bus.in_op     = op;
      bus.in_co     = co;
      bus.in_c_msb  = cm;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check({tag, "_valid"},  {31'd0, bus.out_valid}, 32'd1);
      check({tag, "_result"}, bus.out_result, r);
      check({tag, "_op"},     {29'd0, bus.out_op}, {29'd0, op});
      check({tag, "_flags"},  {28'd0, bus.out_flags}, {28'd0, ef});
      @(posedge clk);
      @(negedge clk);
      exp_cnt++;
      check({tag, "_drained"}, {31'd0, bus.out_valid}, 32'd0);
      check({tag, "_cnt"}, {28'd0, retire_cnt}, exp_cnt % 16);
   endtask

   initial begin
      n_vec = 0;
      n_miss = 0;
      exp_cnt = 0;
      reset_n       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_result = '0;
      bus.in_op     = '0;
      bus.in_co     = 1'b0;
      bus.in_c_msb  = 1'b0;
      bus.out_ready = 1'b1;

      // Reset state and in_ready release timing.
      repeat (2) @(negedge clk);
      check("rst_in_ready",  {31'd0, bus.in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_out_result", bus.out_result, 32'd0);
      check("rst_out_flags", {28'd0, bus.out_flags}, 32'd0);
      check("rst_cnt", {28'd0, retire_cnt}, 32'd0);
      reset_n = 1'b1;
      #1;
      check("rel_in_ready_before_edge", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
      check("rel_in_ready_after_edge", {31'd0, bus.in_ready}, 32'd1);

      // Flag derivation per opcode class.
      send("add_zero",   32'h0000_0000, 3'b110, 1'b1, 1'b1, 4'b1010);
      send("sub_ovf",    32'h8000_0000, 3'b111, 1'b0, 1'b1, 4'b0101);
      send("and_mask",   32'hFFFF_FFFF, 3'b010, 1'b1, 1'b0, 4'b0100);
      send("xor_plain",  32'h0000_1234, 3'b100, 1'b1, 1'b1, 4'b0000);
      send("add_carry",  32'h7FFF_FFFF, 3'b110, 1'b1, 1'b1, 4'b1000);
      send("nota_neg",   32'h8000_0001, 3'b000, 1'b1, 1'b0, 4'b0100);

      // Stall: A and B fill the queue, C is held off until a pop.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_op     = 3'b011;
      bus.in_co     = 1'b0;
      bus.in_c_msb  = 1'b0;
      bus.in_result = 32'h11;
      @(posedge clk);
      @(negedge clk);
      check("stall_one_in_ready", {31'd0, bus.in_ready}, 32'd1);
      bus.in_result = 32'h22;
      @(posedge clk);
      @(negedge clk);
      bus.in_result = 32'h33;
      check("stall_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("stall_head_a", bus.out_result, 32'h11);
      @(posedge clk);
      @(negedge clk);
      check("stall_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("stall_hold_a", bus.out_result, 32'h11);
      check("stall_hold_cnt", {28'd0, retire_cnt}, exp_cnt % 16);
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      exp_cnt++;
      check("drain_b", bus.out_result, 32'h22);
      check("drain_b_in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      exp_cnt++;
      bus.in_valid = 1'b0;
      check("drain_c", bus.out_result, 32'h33);
      check("drain_c_valid", {31'd0, bus.out_valid}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      exp_cnt++;
      check("drain_empty", {31'd0, bus.out_valid}, 32'd0);
      check("drain_hold_last", bus.out_result, 32'h33);
      check("drain_cnt", {28'd0, retire_cnt}, exp_cnt % 16);

      // Bring the total to 17 retired results: the 4-bit counter reads 1.
      for (int i = 0; i < 8; i++)
         send("wrap", 32'h100 + i, 3'b101, 1'b0, 1'b0, 4'b0000);
      check("wrap_cnt17", {28'd0, retire_cnt}, 32'd1);

      // Asynchronous reset with a full queue.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_op     = 3'b110;
      bus.in_result = 32'hAA;
      @(posedge clk);
      @(negedge clk);
      bus.in_result = 32'hBB;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
      check("pre_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      check("mid_rst_result", bus.out_result, 32'd0);
      check("mid_rst_cnt", {28'd0, retire_cnt}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      bus.out_ready = 1'b1;
      exp_cnt = 0;
      @(negedge clk);
      send("post_rst", 32'hFFFF_0000, 3'b111, 1'b1, 1'b0, 4'b1101);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
